qspi_flash_arbiter: RTL and testbench

- Shares the single QSPI flash/PSRAM master between the CPU instruction-fetch port and the CPU data port.
- Keeps one continuous quad read stream open for sequential instruction fetches, with a one-word prefetch buffer.
- Breaks the stream (stop + restart) on a branch, a flush, buffer overflow or a data access.
- Sits between the CPU bus adapters and the QSPI master; only this block drives the master's command inputs.

---
 rtl/qspi_flash_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_qspi_flash_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_arbiter.sv
// -----------------------------------------------------------------------------
// qspi_flash_arbiter
//
// Shares one QSPI flash/PSRAM master between the CPU instruction-fetch port and
// the CPU data port. Sequential instruction fetches are served from a single
// continuous quad read stream through a one-word prefetch buffer. The stream
// is broken (m_stop, then a fresh m_start) on a branch, a flush, a buffer
// overflow or any data access. Data requests win over fetch requests.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   if_req/if_addr      fetch request (held until if_ack), halfword address
//   if_flush            one-cycle pulse, discards stream and prefetch word
//   if_ack/if_rdata     one-cycle ack with the raw instruction word
//   d_req/d_we/d_addr   data request (held until d_ack), direction, address
//   d_len/d_wdata       transfer length in bits, write data
//   d_ack/d_rdata       one-cycle ack with read data (0 for writes)
//   m_start/m_stop      one-cycle start / forced-stop pulses to the master
//   m_we/m_is_instr     registered command, held for the whole transaction
//   m_addr/m_len        registered command address and length
//   m_wdata             registered write data
//   m_done/m_rdata      master completion (per word in stream mode), data
// -----------------------------------------------------------------------------
module qspi_flash_arbiter #(
    parameter logic [5:0] FETCH_LEN = 6'd32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [23:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [23:0] d_addr,
    input  logic [5:0]  d_len,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_start,
    output logic        m_stop,
    output logic        m_we,
    output logic        m_is_instr,
    output logic [23:0] m_addr,
    output logic [5:0]  m_len,
    output logic [31:0] m_wdata,
    input  logic        m_done,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_STREAM = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t      r_state,       w_state_nxt;
    logic        r_m_start,     w_m_start_nxt;
    logic        r_m_stop,      w_m_stop_nxt;
    logic        r_m_we,        w_m_we_nxt;
    logic        r_m_is_instr,  w_m_is_instr_nxt;
    logic [23:0] r_m_addr,      w_m_addr_nxt;
    logic [5:0]  r_m_len,       w_m_len_nxt;
    logic [31:0] r_m_wdata,     w_m_wdata_nxt;
    logic        r_if_ack,      w_if_ack_nxt;
    logic [31:0] r_if_rdata,    w_if_rdata_nxt;
    logic        r_d_ack,       w_d_ack_nxt;
    logic [31:0] r_d_rdata,     w_d_rdata_nxt;
    logic [31:0] r_buf,         w_buf_nxt;
    logic [23:0] r_buf_addr,    w_buf_addr_nxt;
    logic        r_buf_valid,   w_buf_valid_nxt;
    logic [23:0] r_stream_addr, w_stream_addr_nxt;
    logic [1:0]  r_wait_cnt,    w_wait_cnt_nxt;

    // A requester only drops its request after seeing the ack, so during the
    // ack cycle the request line still shows the old, already-served request.
    logic        w_if_req;
    logic        w_d_req;
    logic [23:0] w_head;
    logic        w_buf_hit;
    logic        w_consume;
    logic        w_branch;
    logic        w_overflow;
    logic        w_break;

    assign w_if_req   = if_req & ~r_if_ack;
    assign w_d_req    = d_req & ~r_d_ack;
    // Next instruction the stream owes the CPU: the buffered word if any,
    // otherwise the word the master will deliver next.
    assign w_head     = r_buf_valid ? r_buf_addr : r_stream_addr;
    assign w_buf_hit  = r_buf_valid & ~if_flush & (if_addr == r_buf_addr);
    assign w_consume  = w_if_req & w_buf_hit;
    assign w_branch   = w_if_req & (if_addr != w_head);
    // A word arriving into a full, unconsumed buffer has nowhere to go.
    assign w_overflow = m_done & r_buf_valid & ~w_consume;
    assign w_break    = w_branch | w_d_req | if_flush;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_state_nxt       = r_state;
        w_m_start_nxt     = 1'b0;
        w_m_stop_nxt      = 1'b0;
        w_m_we_nxt        = r_m_we;
        w_m_is_instr_nxt  = r_m_is_instr;
        w_m_addr_nxt      = r_m_addr;
        w_m_len_nxt       = r_m_len;
        w_m_wdata_nxt     = r_m_wdata;
        w_if_ack_nxt      = 1'b0;
        w_if_rdata_nxt    = r_if_rdata;
        w_d_ack_nxt       = 1'b0;
        w_d_rdata_nxt     = r_d_rdata;
        w_buf_nxt         = r_buf;
        w_buf_addr_nxt    = r_buf_addr;
        w_buf_valid_nxt   = r_buf_valid & ~if_flush;
        w_stream_addr_nxt = r_stream_addr;
        w_wait_cnt_nxt    = r_wait_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (r_wait_cnt != 2'd0) begin
                    // Give the master time to fall back to its own idle state.
                    w_wait_cnt_nxt = r_wait_cnt - 2'd1;
                end else if (w_d_req) begin
                    w_m_start_nxt    = 1'b1;
                    w_m_we_nxt       = d_we;
                    w_m_is_instr_nxt = 1'b0;
                    w_m_addr_nxt     = d_addr;
                    w_m_len_nxt      = d_len;
                    w_m_wdata_nxt    = d_wdata;
                    w_state_nxt      = S_DATA;
                end else if (w_if_req) begin
                    if (w_buf_hit) begin
                        // Word left over from an overflowed stream: serve it
                        // without waking the master.
                        w_if_ack_nxt    = 1'b1;
                        w_if_rdata_nxt  = r_buf;
                        w_buf_valid_nxt = 1'b0;
                    end else begin
                        w_m_start_nxt     = 1'b1;
                        w_m_we_nxt        = 1'b0;
                        w_m_is_instr_nxt  = 1'b1;
                        w_m_addr_nxt      = if_addr;
                        w_m_len_nxt       = FETCH_LEN;
                        w_m_wdata_nxt     = 32'd0;
                        w_buf_valid_nxt   = 1'b0;
                        w_stream_addr_nxt = if_addr;
                        w_state_nxt       = S_STREAM;
                    end
                end
            end

            S_DATA: begin
                if (m_done) begin
                    w_d_rdata_nxt  = r_m_we ? 32'd0 : m_rdata;
                    w_d_ack_nxt    = 1'b1;
                    w_wait_cnt_nxt = 2'd2;
                    w_state_nxt    = S_IDLE;
                end
            end

            S_STREAM: begin
                if (w_consume) begin
                    w_if_ack_nxt    = 1'b1;
                    w_if_rdata_nxt  = r_buf;
                    w_buf_valid_nxt = 1'b0;
                end
                if (w_break || w_overflow) begin
                    w_m_stop_nxt = 1'b1;
                    w_state_nxt  = S_STOP;
                    // An overflow alone leaves the buffered word still valid;
                    // any other cause makes it stale.
                    if (w_break) begin
                        w_buf_valid_nxt = 1'b0;
                    end
                end else if (m_done) begin
                    // Buffer is empty or being drained this cycle: refill it.
                    w_buf_nxt         = m_rdata;
                    w_buf_addr_nxt    = r_stream_addr;
                    w_buf_valid_nxt   = 1'b1;
                    w_stream_addr_nxt = r_stream_addr +
                                        ((m_rdata[25:24] == 2'b11) ? 24'd4 : 24'd2);
                end
            end

            S_STOP: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_m_start     <= 1'b0;
            r_m_stop      <= 1'b0;
            r_m_we        <= 1'b0;
            r_m_is_instr  <= 1'b0;
            r_m_addr      <= 24'd0;
            r_m_len       <= 6'd0;
            r_m_wdata     <= 32'd0;
            r_if_ack      <= 1'b0;
            r_if_rdata    <= 32'd0;
            r_d_ack       <= 1'b0;
            r_d_rdata     <= 32'd0;
            r_buf         <= 32'd0;
            r_buf_addr    <= 24'd0;
            r_buf_valid   <= 1'b0;
            r_stream_addr <= 24'd0;
            r_wait_cnt    <= 2'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_m_start     <= w_m_start_nxt;
            r_m_stop      <= w_m_stop_nxt;
            r_m_we        <= w_m_we_nxt;
            r_m_is_instr  <= w_m_is_instr_nxt;
            r_m_addr      <= w_m_addr_nxt;
            r_m_len       <= w_m_len_nxt;
            r_m_wdata     <= w_m_wdata_nxt;
            r_if_ack      <= w_if_ack_nxt;
            r_if_rdata    <= w_if_rdata_nxt;
            r_d_ack       <= w_d_ack_nxt;
            r_d_rdata     <= w_d_rdata_nxt;
            r_buf         <= w_buf_nxt;
            r_buf_addr    <= w_buf_addr_nxt;
            r_buf_valid   <= w_buf_valid_nxt;
            r_stream_addr <= w_stream_addr_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    assign if_ack     = r_if_ack;
    assign if_rdata   = r_if_rdata;
    assign d_ack      = r_d_ack;
    assign d_rdata    = r_d_rdata;
    assign m_start    = r_m_start;
    assign m_stop     = r_m_stop;
    assign m_we       = r_m_we;
    assign m_is_instr = r_m_is_instr;
    assign m_addr     = r_m_addr;
    assign m_len      = r_m_len;
    assign m_wdata    = r_m_wdata;

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qspi_flash_arbiter
//
// Directed bench for qspi_flash_arbiter. The master is modelled by driving
// m_done/m_rdata by hand. Inputs change and outputs are sampled on the falling
// clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_qspi_flash_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [23:0] if_addr;
    logic        if_flush;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [23:0] d_addr;
    logic [5:0]  d_len;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_start;
    logic        m_stop;
    logic        m_we;
    logic        m_is_instr;
    logic [23:0] m_addr;
    logic [5:0]  m_len;
    logic [31:0] m_wdata;
    logic        m_done;
    logic [31:0] m_rdata;

    logic [131:0] all_out;
    assign all_out = {if_ack, if_rdata, d_ack, d_rdata, m_start, m_stop, m_we,
                      m_is_instr, m_addr, m_len, m_wdata};

    int n_vec;
    int n_err;

    qspi_flash_arbiter #(.FETCH_LEN(6'd32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_len     (d_len),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .m_start   (m_start),
        .m_stop    (m_stop),
        .m_we      (m_we),
        .m_is_instr(m_is_instr),
        .m_addr    (m_addr),
        .m_len     (m_len),
        .m_wdata   (m_wdata),
        .m_done    (m_done),
        .m_rdata   (m_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_len = '0; d_wdata = '0;
        m_done = 1'b0; m_rdata = '0;
        tick(); tick();
        n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst_n = 1'b1;
        tick();
        n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL post_reset_idle: got %h want 0", all_out); end
    endtask

    task automatic test_cold_fetch();
        if_req = 1'b1; if_addr = 24'h000100;
        tick();
        n_vec++; if (m_start !== 1'b1) begin n_err++; $display("FAIL cold_m_start: got %b want 1", m_start); end
        n_vec++; if (m_is_instr !== 1'b1) begin n_err++; $display("FAIL cold_is_instr: got %b want 1", m_is_instr); end
        n_vec++; if (m_we !== 1'b0) begin n_err++; $display("FAIL cold_we: got %b want 0", m_we); end
        n_vec++; if (m_addr !== 24'h000100) begin n_err++; $display("FAIL cold_addr: got %h want 000100", m_addr); end
        n_vec++; if (m_len !== 6'd32) begin n_err++; $display("FAIL cold_len: got %0d want 32", m_len); end
        tick();
        n_vec++; if (m_start !== 1'b0) begin n_err++; $display("FAIL cold_start_width: got %b want 0", m_start); end
        n_vec++; if (m_addr !== 24'h000100) begin n_err++; $display("FAIL cold_addr_hold: got %h want 000100", m_addr); end
        m_done = 1'b1; m_rdata = 32'h13000000;
        tick();
        m_done = 1'b0;
        n_vec++; if (if_ack !== 1'b0) begin n_err++; $display("FAIL cold_early_ack: got %b want 0", if_ack); end
        tick();
        n_vec++; if (if_ack !== 1'b1) begin n_err++; $display("FAIL cold_ack: got %b want 1", if_ack); end
        n_vec++; if (if_rdata !== 32'h13000000) begin n_err++; $display("FAIL cold_rdata: got %h want 13000000", if_rdata); end
        n_vec++; if (m_stop !== 1'b0) begin n_err++; $display("FAIL cold_no_stop: got %b want 0", m_stop); end
        if_req = 1'b0;
        tick();
        n_vec++; if (if_ack !== 1'b0) begin n_err++; $display("FAIL cold_ack_width: got %b want 0", if_ack); end
    endtask

    // Sequential fetches continuing the cold stream (head 0x104). The third
    // address is only reachable without a stop if the 0x106 word (bits 25:24
    // = 11) advanced the stream by 4 and the 0x104 word (01) by 2.
    task automatic test_compressed();
        logic [23:0] addrs [3];
        logic [31:0] words [3];
        int          stops;
        int          starts;
        addrs[0] = 24'h000104; words[0] = 32'h01000000;
        addrs[1] = 24'h000106; words[1] = 32'h13000000;
        addrs[2] = 24'h00010A; words[2] = 32'h55AA55AA;
        stops = 0; starts = 0;
        for (int i = 0; i < 3; i++) begin
            if_req = 1'b1; if_addr = addrs[i]; m_done = 1'b1; m_rdata = words[i];
            tick();
            m_done = 1'b0;
            stops += int'(m_stop); starts += int'(m_start);
            tick();
            stops += int'(m_stop); starts += int'(m_start);
            n_vec++; if (if_ack !== 1'b1) begin n_err++; $display("FAIL seq_ack[%0d]: got %b want 1", i, if_ack); end
            n_vec++; if (if_rdata !== words[i]) begin n_err++; $display("FAIL seq_rdata[%0d]: got %h want %h", i, if_rdata, words[i]); end
            if_req = 1'b0;
            tick();
            stops += int'(m_stop); starts += int'(m_start);
        end
        n_vec++; if (stops != 0) begin n_err++; $display("FAIL seq_no_stop: got %0d stop pulses want 0", stops); end
        n_vec++; if (starts != 0) begin n_err++; $display("FAIL seq_no_start: got %0d start pulses want 0", starts); end
    endtask

    // Stream head is 0x10C; a fetch at 0x200 must stop and restart there.
    task automatic test_branch();
        if_req = 1'b1; if_addr = 24'h000200;
        tick();
        n_vec++; if (m_stop !== 1'b1) begin n_err++; $display("FAIL branch_stop: got %b want 1", m_stop); end
        n_vec++; if (m_start !== 1'b0) begin n_err++; $display("FAIL branch_no_start_yet: got %b want 0", m_start); end
        tick();
        n_vec++; if (m_stop !== 1'b0) begin n_err++; $display("FAIL branch_stop_width: got %b want 0", m_stop); end
        tick();
        n_vec++; if (m_start !== 1'b1) begin n_err++; $display("FAIL branch_start: got %b want 1", m_start); end
        n_vec++; if (m_addr !== 24'h000200) begin n_err++; $display("FAIL branch_addr: got %h want 000200", m_addr); end
        m_done = 1'b1; m_rdata = 32'h12345678;
        tick();
        m_done = 1'b0;
        tick();
        n_vec++; if (if_ack !== 1'b1) begin n_err++; $display("FAIL branch_ack: got %b want 1", if_ack); end
        n_vec++; if (if_rdata !== 32'h12345678) begin n_err++; $display("FAIL branch_rdata: got %h want 12345678", if_rdata); end
        if_req = 1'b0;
        tick();
    endtask

    // Stream head is 0x202 (0x12345678 has bits 25:24 = 10, so +2).
    task automatic test_data_preempt();
        d_req = 1'b1; d_we = 1'b0; d_addr = 24'h001000; d_len = 6'd32; d_wdata = 32'h0;
        tick();
        n_vec++; if (m_stop !== 1'b1) begin n_err++; $display("FAIL dpre_stop: got %b want 1", m_stop); end
        tick();
        n_vec++; if (m_start !== 1'b0) begin n_err++; $display("FAIL dpre_start_early: got %b want 0", m_start); end
        tick();
        n_vec++; if (m_start !== 1'b1) begin n_err++; $display("FAIL dpre_start: got %b want 1", m_start); end
        n_vec++; if (m_is_instr !== 1'b0) begin n_err++; $display("FAIL dpre_is_instr: got %b want 0", m_is_instr); end
        n_vec++; if (m_we !== 1'b0) begin n_err++; $display("FAIL dpre_we: got %b want 0", m_we); end
        n_vec++; if (m_addr !== 24'h001000) begin n_err++; $display("FAIL dpre_addr: got %h want 001000", m_addr); end
        n_vec++; if (m_len !== 6'd32) begin n_err++; $display("FAIL dpre_len: got %0d want 32", m_len); end
        // A fetch request during the data transaction must not disturb it.
        if_req = 1'b1; if_addr = 24'h000202;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (m_start !== 1'b0 || m_addr !== 24'h001000 || m_is_instr !== 1'b0) begin
                n_err++; $display("FAIL dpre_hold[%0d]: start=%b addr=%h instr=%b want 0/001000/0", i, m_start, m_addr, m_is_instr);
            end
        end
        m_done = 1'b1; m_rdata = 32'hDEADBEEF;
        tick();
        m_done = 1'b0;
        n_vec++; if (d_ack !== 1'b1) begin n_err++; $display("FAIL dpre_ack: got %b want 1", d_ack); end
        n_vec++; if (d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL dpre_rdata: got %h want deadbeef", d_rdata); end
        n_vec++; if (if_ack !== 1'b0) begin n_err++; $display("FAIL dpre_no_if_ack: got %b want 0", if_ack); end
        d_req = 1'b0;
        tick();
        n_vec++; if (d_ack !== 1'b0 || m_start !== 1'b0) begin n_err++; $display("FAIL dpre_gap1: ack=%b start=%b want 0/0", d_ack, m_start); end
        tick();
        n_vec++; if (m_start !== 1'b0) begin n_err++; $display("FAIL dpre_gap2: got %b want 0", m_start); end
        tick();
        n_vec++; if (m_start !== 1'b1) begin n_err++; $display("FAIL dpre_restart: got %b want 1", m_start); end
        n_vec++; if (m_addr !== 24'h000202 || m_is_instr !== 1'b1) begin
            n_err++; $display("FAIL dpre_restart_cmd: addr=%h instr=%b want 000202/1", m_addr, m_is_instr);
        end
        m_done = 1'b1; m_rdata = 32'h03000000;
        tick();
        m_done = 1'b0;
        tick();
        n_vec++; if (if_ack !== 1'b1 || if_rdata !== 32'h03000000) begin
            n_err++; $display("FAIL dpre_fetch: ack=%b rdata=%h want 1/03000000", if_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();
    endtask

    // Stream head is 0x206, buffer empty, no fetch pending.
    task automatic test_overflow();
        m_done = 1'b1; m_rdata = 32'hA1000000;
        tick();
        n_vec++; if (m_stop !== 1'b0) begin n_err++; $display("FAIL ovf_first_word: stop=%b want 0", m_stop); end
        m_rdata = 32'hB2000000;
        tick();
        m_done = 1'b0;
        n_vec++; if (m_stop !== 1'b1) begin n_err++; $display("FAIL ovf_stop: got %b want 1", m_stop); end
        tick();
        n_vec++; if (m_stop !== 1'b0) begin n_err++; $display("FAIL ovf_stop_width: got %b want 0", m_stop); end
        tick();
        n_vec++; if (m_start !== 1'b0) begin n_err++; $display("FAIL ovf_idle: start=%b want 0", m_start); end
        if_req = 1'b1; if_addr = 24'h000206;
        tick();
        n_vec++; if (if_ack !== 1'b1) begin n_err++; $display("FAIL ovf_buf_ack: got %b want 1", if_ack); end
        n_vec++; if (if_rdata !== 32'hA1000000) begin n_err++; $display("FAIL ovf_buf_rdata: got %h want a1000000", if_rdata); end
        n_vec++; if (m_start !== 1'b0) begin n_err++; $display("FAIL ovf_no_start: got %b want 0", m_start); end
        if_req = 1'b0;
        tick();
        n_vec++; if (if_ack !== 1'b0 || m_start !== 1'b0) begin n_err++; $display("FAIL ovf_after: ack=%b start=%b want 0/0", if_ack, m_start); end
    endtask

    // A word buffered at 0x20A is discarded by a flush, so a later fetch at
    // 0x20A must start the master instead of being served from the buffer.
    task automatic test_flush();
        if_req = 1'b1; if_addr = 24'h000208;
        tick();
        n_vec++; if (m_start !== 1'b1 || m_addr !== 24'h000208) begin
            n_err++; $display("FAIL flush_start: start=%b addr=%h want 1/000208", m_start, m_addr);
        end
        m_done = 1'b1; m_rdata = 32'h11000000;
        tick();
        m_done = 1'b0;
        tick();
        n_vec++; if (if_ack !== 1'b1 || if_rdata !== 32'h11000000) begin
            n_err++; $display("FAIL flush_pre_fetch: ack=%b rdata=%h want 1/11000000", if_ack, if_rdata);
        end
        if_req = 1'b0; m_done = 1'b1; m_rdata = 32'h22000000;
        tick();
        m_done = 1'b0; if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        n_vec++; if (m_stop !== 1'b1) begin n_err++; $display("FAIL flush_stop: got %b want 1", m_stop); end
        tick();
        if_req = 1'b1; if_addr = 24'h00020A;
        tick();
        n_vec++; if (if_ack !== 1'b0) begin n_err++; $display("FAIL flush_stale_ack: got %b want 0", if_ack); end
        n_vec++; if (m_start !== 1'b1 || m_addr !== 24'h00020A) begin
            n_err++; $display("FAIL flush_restart: start=%b addr=%h want 1/00020a", m_start, m_addr);
        end
    endtask

    // Both requests pending after a stop: data goes first; write returns 0.
    task automatic test_write_priority();
        m_done = 1'b1; m_rdata = 32'h44000000;
        tick();
        m_done = 1'b0;
        tick();
        n_vec++; if (if_ack !== 1'b1 || if_rdata !== 32'h44000000) begin
            n_err++; $display("FAIL wr_fetch: ack=%b rdata=%h want 1/44000000", if_ack, if_rdata);
        end
        if_addr = 24'h00020C;
        d_req = 1'b1; d_we = 1'b1; d_addr = 24'h003000; d_len = 6'd16; d_wdata = 32'hCAFE0000;
        tick();
        n_vec++; if (m_stop !== 1'b1) begin n_err++; $display("FAIL wr_stop: got %b want 1", m_stop); end
        tick();
        tick();
        n_vec++; if (m_start !== 1'b1 || m_is_instr !== 1'b0 || m_we !== 1'b1) begin
            n_err++; $display("FAIL wr_start: start=%b instr=%b we=%b want 1/0/1", m_start, m_is_instr, m_we);
        end
        n_vec++; if (m_addr !== 24'h003000 || m_len !== 6'd16 || m_wdata !== 32'hCAFE0000) begin
            n_err++; $display("FAIL wr_cmd: addr=%h len=%0d wdata=%h want 003000/16/cafe0000", m_addr, m_len, m_wdata);
        end
        tick(); tick();
        m_done = 1'b1; m_rdata = 32'h12345678;
        tick();
        m_done = 1'b0;
        n_vec++; if (d_ack !== 1'b1 || d_rdata !== 32'h0) begin
            n_err++; $display("FAIL wr_ack: ack=%b rdata=%h want 1/00000000", d_ack, d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (m_start !== 1'b1 || m_addr !== 24'h00020C || m_is_instr !== 1'b1 || m_we !== 1'b0) begin
            n_err++; $display("FAIL wr_refetch: start=%b addr=%h instr=%b we=%b want 1/00020c/1/0", m_start, m_addr, m_is_instr, m_we);
        end
    endtask

    task automatic test_reset_mid_data();
        d_req = 1'b1; d_we = 1'b0; d_addr = 24'h004000; d_len = 6'd8; d_wdata = 32'h0;
        tick(); tick(); tick();
        n_vec++; if (m_start !== 1'b1 || m_addr !== 24'h004000 || m_len !== 6'd8) begin
            n_err++; $display("FAIL rst_data_start: start=%b addr=%h len=%0d want 1/004000/8", m_start, m_addr, m_len);
        end
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL rst_async: got %h want 0", all_out); end
        d_req = 1'b0; if_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        m_done = 1'b1; m_rdata = 32'hFFFFFFFF;
        tick();
        m_done = 1'b0;
        n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL rst_spurious: got %h want 0", all_out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (all_out !== '0) begin n_err++; $display("FAIL rst_quiet[%0d]: got %h want 0", i, all_out); end
        end
        if_req = 1'b1; if_addr = 24'h000300;
        tick();
        n_vec++; if (m_start !== 1'b1 || m_addr !== 24'h000300 || if_ack !== 1'b0) begin
            n_err++; $display("FAIL rst_fresh_fetch: start=%b addr=%h ack=%b want 1/000300/0", m_start, m_addr, if_ack);
        end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_cold_fetch();
        test_compressed();
        test_branch();
        test_data_preempt();
        test_overflow();
        test_flush();
        test_write_priority();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
